// File: rtl/calc_pkg.sv
// Width helpers for the frame RAM port.
package calc_pkg;
  // The RAM stores one byte per location.
  function automatic int num_data_a_bits();
    return 8;
  endfunction

  // Byte-address width covering every row. The panel is split into two
  // halves of HALFHEIGHT rows, so the row field is one bit wider than a half.
  function automatic int num_address_a_bits(input int w, input int h,
                                            input int bpp, input int hh);
    int row_bits;
    row_bits = (hh * 2 >= h) ? $clog2(hh) + 1 : $clog2(h);
    return $clog2(w * bpp) + row_bits;
  endfunction
endpackage

// File: rtl/control_module_pkg.sv
// Command byte codes of the serial panel protocol.
package control_module_pkg;
  localparam logic [7:0] CMD_LINE   = 8'h4C;  // 'L'
  localparam logic [7:0] CMD_BRIGHT = 8'h54;  // 'T'
  localparam logic [7:0] CMD_R_ON   = 8'h52;  // 'R'
  localparam logic [7:0] CMD_G_ON   = 8'h47;  // 'G'
  localparam logic [7:0] CMD_B_ON   = 8'h42;  // 'B'
  localparam logic [7:0] CMD_R_OFF  = 8'h72;  // 'r'
  localparam logic [7:0] CMD_G_OFF  = 8'h67;  // 'g'
  localparam logic [7:0] CMD_B_OFF  = 8'h62;  // 'b'
endpackage

// File: rtl/params_pkg.sv
// Display geometry defaults shared by the LED panel blocks.
package params_pkg;
  localparam int BYTES_PER_PIXEL   = 2;
  localparam int PIXEL_WIDTH       = 64;
  localparam int PIXEL_HEIGHT      = 32;
  localparam int PIXEL_HALFHEIGHT  = 16;
  localparam int BRIGHTNESS_LEVELS = 6;
endpackage

// File: rtl/control_module.sv
// Serial command decoder: channel enables, brightness planes and row
// uploads into the frame RAM.
module control_module
  import control_module_pkg::*;
#(
  parameter int BYTES_PER_PIXEL   = params_pkg::BYTES_PER_PIXEL,
  parameter int PIXEL_WIDTH       = params_pkg::PIXEL_WIDTH,
  parameter int PIXEL_HEIGHT      = params_pkg::PIXEL_HEIGHT,
  parameter int PIXEL_HALFHEIGHT  = params_pkg::PIXEL_HALFHEIGHT,
  parameter int BRIGHTNESS_LEVELS = params_pkg::BRIGHTNESS_LEVELS,
  parameter int _UNUSED           = 0
) (
  input  logic clk_in,
  input  logic reset,
  input  logic [7:0] data_rx,
  input  logic data_ready_n,
  output logic busy,
  output logic [2:0] rgb_enable,
  output logic [BRIGHTNESS_LEVELS-1:0] brightness_enable,
  output logic [calc_pkg::num_data_a_bits()-1:0] ram_data_out,
  output logic [calc_pkg::num_address_a_bits(PIXEL_WIDTH, PIXEL_HEIGHT,
                BYTES_PER_PIXEL, PIXEL_HALFHEIGHT)-1:0] ram_address,
  output logic ram_write_enable,
  output logic ram_clk_enable
`ifdef DEBUGGER
  ,
  output logic [7:0] num_commands_processed
`endif
);

  localparam int ADDR_W    = calc_pkg::num_address_a_bits(PIXEL_WIDTH, PIXEL_HEIGHT,
                               BYTES_PER_PIXEL, PIXEL_HALFHEIGHT);
  localparam int DATA_W    = calc_pkg::num_data_a_bits();
  localparam int ROW_BYTES = PIXEL_WIDTH * BYTES_PER_PIXEL;
  localparam int CNT_W     = $clog2(ROW_BYTES);
  localparam int ROW_W     = $clog2(PIXEL_HEIGHT);

  typedef enum logic [1:0] {IDLE, READ_ROW, READ_PIXELS, READ_BRIGHT} state_t;

  state_t             state;
  logic               rdy_q;
  logic               accept;
  logic [CNT_W-1:0]   cnt;
  logic [ROW_W-1:0]   row;
  logic [7:0]         cmd_count;

  // Strobe is active on its falling edge; rdy_q holds last cycle's sample.
  assign accept = rdy_q & ~data_ready_n;

`ifdef DEBUGGER
  assign num_commands_processed = cmd_count;
`endif

  // Edge detect, command FSM and registered RAM write port.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state             <= IDLE;
      rdy_q             <= 1'b1;
      busy              <= 1'b0;
      rgb_enable        <= 3'b111;
      brightness_enable <= '1;
      ram_data_out      <= '0;
      ram_address       <= '0;
      ram_write_enable  <= 1'b0;
      ram_clk_enable    <= 1'b0;
      cnt               <= '0;
      row               <= '0;
      cmd_count         <= '0;
    end else begin
      rdy_q            <= data_ready_n;
      ram_write_enable <= 1'b0;
      ram_clk_enable   <= 1'b0;
      if (accept) begin
        case (state)
          IDLE: begin
            case (data_rx)
              CMD_R_ON:   begin rgb_enable[2] <= 1'b1; cmd_count <= cmd_count + 8'd1; end
              CMD_G_ON:   begin rgb_enable[1] <= 1'b1; cmd_count <= cmd_count + 8'd1; end
              CMD_B_ON:   begin rgb_enable[0] <= 1'b1; cmd_count <= cmd_count + 8'd1; end
              CMD_R_OFF:  begin rgb_enable[2] <= 1'b0; cmd_count <= cmd_count + 8'd1; end
              CMD_G_OFF:  begin rgb_enable[1] <= 1'b0; cmd_count <= cmd_count + 8'd1; end
              CMD_B_OFF:  begin rgb_enable[0] <= 1'b0; cmd_count <= cmd_count + 8'd1; end
              CMD_LINE:   begin state <= READ_ROW;    busy <= 1'b1; end
              CMD_BRIGHT: begin state <= READ_BRIGHT; busy <= 1'b1; end
              default: ;
            endcase
          end
          READ_BRIGHT: begin
            brightness_enable <= data_rx[BRIGHTNESS_LEVELS-1:0];
            cmd_count         <= cmd_count + 8'd1;
            busy              <= 1'b0;
            state             <= IDLE;
          end
          READ_ROW: begin
            // PIXEL_HEIGHT is a power of two, so masking is a truncation.
            row   <= data_rx[ROW_W-1:0];
            cnt   <= CNT_W'(ROW_BYTES - 1);
            state <= READ_PIXELS;
          end
          READ_PIXELS: begin
            // Row is filled from its last byte down to byte 0.
            ram_data_out     <= DATA_W'(data_rx);
            ram_address      <= ADDR_W'(row) * ADDR_W'(ROW_BYTES) + ADDR_W'(cnt);
            ram_write_enable <= 1'b1;
            ram_clk_enable   <= 1'b1;
            cnt              <= cnt - 1'b1;
            if (cnt == '0) begin
              state     <= IDLE;
              busy      <= 1'b0;
              cmd_count <= cmd_count + 8'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_control_module.sv
// Scoreboard bench for control_module: pixel writes are predicted when the
// byte is sent and checked when the RAM strobe fires.
module tb_control_module;
  logic        clk_in = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  data_rx = 8'h00;
  logic        data_ready_n = 1'b1;
  logic        busy;
  logic [2:0]  rgb_enable;
  logic [5:0]  brightness_enable;
  logic [7:0]  ram_data_out;
  logic [11:0] ram_address;
  logic        ram_write_enable;
  logic        ram_clk_enable;

  int total = 0;
  int bad = 0;
  int n_writes = 0;
  logic [19:0] exp_q[$];   // {address, data}

  control_module dut (
    .clk_in(clk_in), .reset(reset), .data_rx(data_rx),
    .data_ready_n(data_ready_n), .busy(busy), .rgb_enable(rgb_enable),
    .brightness_enable(brightness_enable), .ram_data_out(ram_data_out),
    .ram_address(ram_address), .ram_write_enable(ram_write_enable),
    .ram_clk_enable(ram_clk_enable)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Write monitor: every strobe must match the oldest predicted write.
  always @(negedge clk_in) begin
    if (reset && ram_write_enable) begin
      n_writes++;
      chk("clk_en", 32'(ram_clk_enable), 32'd1);
      if (exp_q.size() == 0) chk("unexpected_write", 32'(ram_address), 32'hFFFF_FFFF);
      else begin
        logic [19:0] e;
        e = exp_q.pop_front();
        chk("wr_addr", 32'(ram_address), 32'(e[19:8]));
        chk("wr_data", 32'(ram_data_out), 32'(e[7:0]));
      end
    end
  end

  // One falling strobe edge per byte; returns on the negedge after acceptance.
  task automatic send(input logic [7:0] b, input int low_cycles = 1);
    @(negedge clk_in);
    data_rx = b;
    data_ready_n = 1'b0;
    repeat (low_cycles) @(negedge clk_in);
    data_ready_n = 1'b1;
  endtask

  initial begin
    logic [7:0] c;
    int w0;
    // Reset state
    repeat (2) @(negedge clk_in);
    chk("rst_rgb_async", 32'(rgb_enable), 32'h7);
    reset = 1'b1;
    repeat (2) @(negedge clk_in);
    chk("rst_rgb", 32'(rgb_enable), 32'h7);
    chk("rst_bright", 32'(brightness_enable), 32'h3F);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_we", 32'(ram_write_enable), 32'd0);
    chk("rst_addr", 32'(ram_address), 32'd0);
    chk("rst_cnt", 32'(dut.cmd_count), 32'd0);

    // Channel enables
    send("b"); chk("rgb_b", 32'(rgb_enable), 32'h6);
    send("r"); chk("rgb_r", 32'(rgb_enable), 32'h2);
    send("R"); chk("rgb_R", 32'(rgb_enable), 32'h6);
    send(" "); chk("rgb_sp", 32'(rgb_enable), 32'h6);
    chk("cnt_rgb", 32'(dut.cmd_count), 32'd3);

    // Row upload: row 0x2D & 31 = 13
    send("L");  chk("busy_L", 32'(busy), 32'd1);
    send(8'h2D); chk("busy_row", 32'(busy), 32'd1);
    w0 = n_writes;
    for (int i = 0; i < 128; i++) begin
      c = 8'h30 + 8'(7 - (i / 2) % 8);
      exp_q.push_back({12'(13 * 128 + 127 - i), c});
      send(c);
      if (i < 127) begin
        if (busy !== 1'b1) chk("busy_pix", 32'(busy), 32'd1);
      end else chk("busy_end", 32'(busy), 32'd0);
    end
    repeat (2) @(negedge clk_in);
    chk("n_writes", 32'(n_writes - w0), 32'd128);
    chk("q_empty", 32'(exp_q.size()), 32'd0);
    chk("cnt_L", 32'(dut.cmd_count), 32'd4);

    // Brightness
    send("T");  chk("busy_T", 32'(busy), 32'd1);
    send(8'h15);
    chk("bright", 32'(brightness_enable), 32'h15);
    chk("busy_T_end", 32'(busy), 32'd0);
    chk("cnt_T", 32'(dut.cmd_count), 32'd5);

    // Strobe held low for 5 cycles is a single byte
    send("g", 5);
    repeat (3) @(negedge clk_in);
    chk("hold_rgb", 32'(rgb_enable), 32'h4);
    chk("hold_cnt", 32'(dut.cmd_count), 32'd6);

    // Reset mid-upload abandons the row
    send("L"); send(8'h05);
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back({12'(5 * 128 + 127 - i), 8'(8'hA0 + i)});
      send(8'(8'hA0 + i));
    end
    @(negedge clk_in);
    #2 reset = 1'b0;
    #1;
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_rgb", 32'(rgb_enable), 32'h7);
    chk("rst_mid_we", 32'(ram_write_enable), 32'd0);
    @(negedge clk_in);
    reset = 1'b1;
    chk("q_after_rst", 32'(exp_q.size()), 32'd0);
    w0 = n_writes;
    send("r");
    repeat (3) @(negedge clk_in);
    chk("post_rst_rgb", 32'(rgb_enable), 32'h3);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_writes", 32'(n_writes - w0), 32'd0);
    chk("post_rst_cnt", 32'(dut.cmd_count), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end
endmodule
